// File: rtl/namuru_wbm_dump.sv
// Wishbone read initiator that drains the namuru correlator register window
// into a first-word fall-through valid/ready stream on every trigger pulse.
module namuru_wbm_dump #(
   parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
   parameter int unsigned NREGS      = 8,
   parameter int unsigned GAP_CYCLES = 8,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        trigger,
   input  logic        err_clr,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic [31:0] out_dat,
   output logic [7:0]  out_idx,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        overrun_err,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0]  LAST_K   = 8'(NREGS - 1);
   localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] dat;
      logic [7:0]  idx;
      logic        last;
   } entry_t;

   logic [1:0]    state_q, state_d;
   logic [7:0]    k_q, k_d;
   logic [7:0]    gap_q, gap_d;
   logic [15:0]   to_q, to_d;
   logic          stb_q, stb_d;
   logic [31:0]   adr_q, adr_d;
   logic          busy_q, busy_d;
   logic          ovr_q, ovr_d;
   logic          tmo_q, tmo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   entry_t        fifo_q [FIFO_DEPTH];
   entry_t        fifo_d [FIFO_DEPTH];

   logic          has_room;
   logic          push;
   logic          pop;
   logic          tmo_set;
   logic          ovr_set;
   logic [CW-1:0] wr_idx;
   entry_t        push_e;

   // Room is judged on the current count only; a same-cycle pop is not credited.
   assign has_room = (cnt_q < DEPTH_C);
   assign pop      = valid_q & out_ready;
   assign ovr_set  = trigger & busy_q;
   assign push_e   = '{dat: wbm_dat_i, idx: k_q, last: (k_q == LAST_K)};

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      gap_d   = gap_q;
      to_d    = '0;
      stb_d   = stb_q;
      busy_d  = busy_q;
      push    = 1'b0;
      tmo_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               k_d    = '0;
               busy_d = 1'b1;
               if (has_room) begin
                  state_d = S_REQ;
                  stb_d   = 1'b1;
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_REQ: begin
            if (wbm_ack_i) begin
               push  = 1'b1;
               stb_d = 1'b0;
               if (k_q == LAST_K) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  k_d     = k_q + 8'd1;
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
               end
            end else if (to_q == TO_LAST) begin
               stb_d   = 1'b0;
               tmo_set = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + 16'd1;
            end
         end
         S_GAP: begin
            if (gap_q == 8'd0) begin
               if (has_room) begin
                  state_d = S_REQ;
                  stb_d   = 1'b1;
               end else begin
                  state_d = S_HOLD;
               end
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (has_room) begin
               state_d = S_REQ;
               stb_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      adr_d = BASE_ADR + {22'd0, k_d, 2'b00};
      // A clear beats a same-cycle set of either sticky flag.
      ovr_d = err_clr ? 1'b0 : (ovr_q | ovr_set);
      tmo_d = err_clr ? 1'b0 : (tmo_q | tmo_set);
   end

   // Shift-register FIFO: entry 0 is always the head, so the stream outputs
   // come straight from flops.
   always_comb begin
      fifo_d = fifo_q;
      wr_idx = pop ? (cnt_q - CW'(1)) : cnt_q;
      if (pop) begin
         for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
            fifo_d[i] = fifo_q[i+1];
         end
      end
      if (push) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (wr_idx == CW'(i)) begin
               fifo_d[i] = push_e;
            end
         end
      end
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      valid_d = (cnt_d != '0);
   end

   // NOTE: state is updated only with non-blocking assignments from the _d
   // values, so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         gap_q   <= '0;
         to_q    <= '0;
         stb_q   <= 1'b0;
         adr_q   <= BASE_ADR;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         // NOTE: the FIFO storage is reset because entry 0 drives out_dat,
         // out_idx and out_last directly and those have defined reset values.
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         gap_q   <= gap_d;
         to_q    <= to_d;
         stb_q   <= stb_d;
         adr_q   <= adr_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         fifo_q  <= fifo_d;
      end
   end

   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = '0;
   assign wbm_sel_o   = 4'hF;
   assign wbm_we_o    = 1'b0;
   assign wbm_stb_o   = stb_q;
   assign wbm_cyc_o   = stb_q;
   assign out_dat     = fifo_q[0].dat;
   assign out_idx     = fifo_q[0].idx;
   assign out_last    = fifo_q[0].last;
   assign out_valid   = valid_q;
   assign busy        = busy_q;
   assign overrun_err = ovr_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_namuru_wbm_dump.sv
// Bench for namuru_wbm_dump: a 4-register instance for the nominal, timeout,
// overrun and reset cases, and an 8-register depth-2 instance for backpressure.
module tb_namuru_wbm_dump;

   localparam int GAP = 8;

   typedef struct {
      logic [31:0] exp_adr;
      int          delay;
      logic [31:0] dat;
      logic [7:0]  idx;
      logic        last;
   } vec_t;

   logic clk;
   logic rst_n;
   int   cyc_cnt;
   int   checks;
   int   failures;

   logic        a_trig, a_clr, a_ack, a_ordy;
   logic [31:0] a_dati;
   logic [31:0] a_adr, a_dato, a_odat;
   logic [3:0]  a_sel;
   logic        a_we, a_stb, a_cyc, a_olast, a_oval, a_busy, a_ovr, a_tmo;
   logic [7:0]  a_oidx;

   logic        b_trig, b_clr, b_ack, b_ordy;
   logic [31:0] b_dati;
   logic [31:0] b_adr, b_dato, b_odat;
   logic [3:0]  b_sel;
   logic        b_we, b_stb, b_cyc, b_olast, b_oval, b_busy, b_ovr, b_tmo;
   logic [7:0]  b_oidx;

   logic [40:0] sb_a[$];
   logic [40:0] sb_b[$];
   int          a_got;
   int          b_got;
   int          last_ack_cyc;

   namuru_wbm_dump #(
      .BASE_ADR(32'h0000_0100), .NREGS(4), .GAP_CYCLES(GAP), .TIMEOUT(20), .FIFO_DEPTH(4)
   ) u_a (
      .sys_clk(clk), .sys_rst(rst_n), .trigger(a_trig), .err_clr(a_clr),
      .wbm_adr_o(a_adr), .wbm_dat_o(a_dato), .wbm_sel_o(a_sel), .wbm_we_o(a_we),
      .wbm_stb_o(a_stb), .wbm_cyc_o(a_cyc), .wbm_dat_i(a_dati), .wbm_ack_i(a_ack),
      .out_dat(a_odat), .out_idx(a_oidx), .out_last(a_olast), .out_valid(a_oval),
      .out_ready(a_ordy), .busy(a_busy), .overrun_err(a_ovr), .timeout_err(a_tmo)
   );

   namuru_wbm_dump #(
      .BASE_ADR(32'h0000_0000), .NREGS(8), .GAP_CYCLES(GAP), .TIMEOUT(255), .FIFO_DEPTH(2)
   ) u_b (
      .sys_clk(clk), .sys_rst(rst_n), .trigger(b_trig), .err_clr(b_clr),
      .wbm_adr_o(b_adr), .wbm_dat_o(b_dato), .wbm_sel_o(b_sel), .wbm_we_o(b_we),
      .wbm_stb_o(b_stb), .wbm_cyc_o(b_cyc), .wbm_dat_i(b_dati), .wbm_ack_i(b_ack),
      .out_dat(b_odat), .out_idx(b_oidx), .out_last(b_olast), .out_valid(b_oval),
      .out_ready(b_ordy), .busy(b_busy), .overrun_err(b_ovr), .timeout_err(b_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Stream monitors: a transfer is the valid&ready seen half a cycle before the edge.
   always @(negedge clk) begin
      if (rst_n && a_oval && a_ordy) begin
         if (sb_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_stream_unexpected actual=%0h required=none", {a_odat, a_oidx, a_olast});
         end else begin
            check("a_stream", {a_odat, a_oidx, a_olast}, sb_a.pop_front());
            a_got++;
         end
      end
      if (rst_n && b_oval && b_ordy) begin
         if (sb_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_stream_unexpected actual=%0h required=none", {b_odat, b_oidx, b_olast});
         end else begin
            check("b_stream", {b_odat, b_oidx, b_olast}, sb_b.pop_front());
            b_got++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_start();
      a_trig = 1'b1;
      tick();
      a_trig = 1'b0;
      check("a_busy_after_trig", a_busy, 1'b1);
      check("a_stb_after_trig", a_stb, 1'b1);
      check("a_adr_first", a_adr, 32'h100);
   endtask

   task automatic a_wait_stb(output bit seen);
      int n;
      n = 0;
      while (!a_stb && n < 200) begin
         tick();
         n++;
      end
      seen = a_stb;
      check("a_req_seen", a_stb, 1'b1);
   endtask

   task automatic a_serve(input vec_t v, input bit chk_gap);
      bit seen;
      a_wait_stb(seen);
      if (seen) begin
         if (chk_gap) check("a_gap_min", (cyc_cnt - last_ack_cyc) >= GAP, 1'b1);
         check("a_adr", a_adr, v.exp_adr);
         check("a_cyc_eq_stb", a_cyc, 1'b1);
         repeat (v.delay - 1) tick();
         a_ack  = 1'b1;
         a_dati = v.dat;
         sb_a.push_back({v.dat, v.idx, v.last});
         tick();
         last_ack_cyc = cyc_cnt;
         a_ack  = 1'b0;
         a_dati = 32'hDEAD_BEEF;
         check("a_stb_drop", a_stb, 1'b0);
      end
   endtask

   task automatic a_drain();
      int n;
      n = 0;
      while ((sb_a.size() != 0 || a_oval) && n < 100) begin
         tick();
         n++;
      end
      check("a_drain_empty", sb_a.size(), 0);
      check("a_drain_valid", a_oval, 1'b0);
   endtask

   initial begin
      vec_t vecs[10];
      int   prev_got;
      int   cnt;
      int   seen_stb;
      int   reqs;
      int   w;
      int   bk;
      bit   seen;
      logic [31:0] d;
      int   dl[4];

      checks = 0; failures = 0; a_got = 0; b_got = 0; last_ack_cyc = 0;
      dl[0] = 1; dl[1] = 2; dl[2] = 19; dl[3] = 20;
      for (int k = 0; k < 4; k++) begin
         vecs[k] = '{32'h100 + 32'(4 * k), 6, 32'hA0 + 32'(k), 8'(k), (k == 3)};
         vecs[6+k] = '{32'h100 + 32'(4 * k), dl[k], 32'hC0 + 32'(k), 8'(k), (k == 3)};
      end
      vecs[4] = '{32'h100, 3, 32'hD0, 8'd0, 1'b0};
      vecs[5] = '{32'h104, 3, 32'hD1, 8'd1, 1'b0};

      rst_n = 1'b0;
      a_trig = 0; a_clr = 0; a_ack = 0; a_dati = '0; a_ordy = 1'b1;
      b_trig = 0; b_clr = 0; b_ack = 0; b_dati = '0; b_ordy = 1'b0;
      #12;
      check("rst_a_stb", a_stb, 1'b0);
      check("rst_a_cyc", a_cyc, 1'b0);
      check("rst_a_adr", a_adr, 32'h100);
      check("rst_a_stream", {a_oval, a_odat, a_oidx, a_olast}, '0);
      check("rst_a_flags", {a_busy, a_ovr, a_tmo}, 3'b000);
      check("rst_a_const", {a_dato, a_sel, a_we}, {32'h0, 4'hF, 1'b0});
      check("rst_b_idle", {b_stb, b_busy, b_oval, b_adr}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Nominal dump with 6-cycle acks.
      a_start();
      for (int i = 0; i < 4; i++) a_serve(vecs[i], i > 0);
      check("a_busy_after_last", a_busy, 1'b0);
      a_drain();
      check("a_nominal_count", a_got, 4);

      // Third request never acked; two captured values must still arrive.
      prev_got = a_got;
      a_start();
      for (int i = 4; i < 6; i++) a_serve(vecs[i], i > 4);
      a_wait_stb(seen);
      check("a_tmo_adr", a_adr, 32'h108);
      cnt = 0;
      while (a_stb && cnt < 100) begin
         cnt++;
         tick();
      end
      check("a_tmo_stb_cycles", cnt, 20);
      check("a_tmo_err", a_tmo, 1'b1);
      check("a_tmo_busy", a_busy, 1'b0);
      a_drain();
      check("a_tmo_delivered", a_got - prev_got, 2);

      // Later trigger dumps normally; acks at 1, 2, 19 and 20 cycles.
      a_start();
      for (int i = 6; i < 10; i++) a_serve(vecs[i], i > 6);
      check("a_post_tmo_busy", a_busy, 1'b0);
      check("a_tmo_sticky", a_tmo, 1'b1);
      a_drain();

      // Overrun during a burst, plus a stray ack in GAP that must be ignored.
      a_start();
      a_serve(vecs[0], 1'b0);
      a_ack = 1'b1; a_dati = 32'hBAD0_BAD0;
      tick();
      a_ack = 1'b0;
      a_trig = 1'b1;
      tick();
      a_trig = 1'b0;
      check("a_ovr_set", a_ovr, 1'b1);
      check("a_ovr_busy", a_busy, 1'b1);
      for (int i = 1; i < 4; i++) a_serve(vecs[i], 1'b1);
      seen_stb = 0;
      for (int i = 0; i < 20; i++) begin
         if (a_stb) seen_stb++;
         tick();
      end
      check("a_ovr_no_extra_req", seen_stb, 0);
      a_drain();

      // err_clr together with a second overrun trigger: clear wins.
      a_start();
      a_serve(vecs[0], 1'b0);
      a_trig = 1'b1; a_clr = 1'b1;
      tick();
      a_trig = 1'b0; a_clr = 1'b0;
      check("a_clr_wins_ovr", a_ovr, 1'b0);
      check("a_clr_tmo", a_tmo, 1'b0);
      for (int i = 1; i < 4; i++) a_serve(vecs[i], 1'b1);
      a_drain();

      // Asynchronous reset mid-REQ with a queued entry.
      a_ordy = 1'b0;
      a_start();
      a_serve(vecs[0], 1'b0);
      check("a_valid_queued", a_oval, 1'b1);
      a_wait_stb(seen);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_stb", a_stb, 1'b0);
      check("arst_cyc", a_cyc, 1'b0);
      check("arst_valid", a_oval, 1'b0);
      check("arst_busy", a_busy, 1'b0);
      sb_a.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      a_ordy = 1'b1;
      tick();
      a_start();
      for (int i = 0; i < 4; i++) a_serve(vecs[i], i > 0);
      a_drain();

      // Backpressure on the depth-2, 8-register instance.
      b_trig = 1'b1;
      tick();
      b_trig = 1'b0;
      check("b_busy_after_trig", b_busy, 1'b1);
      reqs = 0; w = 0; bk = 0;
      for (int c = 0; c < 800; c++) begin
         if (c == 199) begin
            check("b_reqs_held", reqs, 2);
            check("b_stb_hold", b_stb, 1'b0);
            check("b_busy_hold", b_busy, 1'b1);
         end
         if (c == 200) b_ordy = 1'b1;
         if (b_ack) begin
            b_ack = 1'b0;
         end else if (b_stb) begin
            if (w == 0) begin
               reqs++;
               check("b_adr", b_adr, 32'(4 * bk));
            end
            w++;
            if (w == 2) begin
               d = 32'hB0 + 32'(bk);
               b_ack = 1'b1;
               b_dati = d;
               sb_b.push_back({d, 8'(bk), (bk == 7)});
               bk++;
               w = 0;
            end
         end
         if (c > 200 && !b_busy && !b_ack && !b_oval && sb_b.size() == 0) break;
         tick();
      end
      check("b_reqs_total", reqs, 8);
      check("b_delivered", b_got, 8);
      check("b_sb_empty", sb_b.size(), 0);
      check("b_busy_end", b_busy, 1'b0);
      check("a_sb_empty", sb_a.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
